// File: rtl/parity_sched.sv
// parity_sched: shared bit-serial odd-parity engine with request arbitration.
// Up to NREQ requesters present WIDTH-bit words. One requester is granted at a
// time. The granted word is shifted through a single parity accumulator at one
// bit per clock, and the result comes back with a one-cycle ack.
// Build option: define PARITY_FIXED_PRIO_EN for fixed priority, where the lowest
// index wins. The default build uses round-robin arbitration starting after the
// last grant.
module parity_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       ack,
  output logic                  done,
  output logic                  parity,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  words [NREQ];
  logic [WIDTH-1:0]  shift_reg;
  logic              acc;
  logic [CW-1:0]     count;
  logic              last_shift;
  logic              any_req;
  logic [IDW-1:0]    winner;
  logic [IDW-1:0]    search_base;
  logic [IDW-1:0]    cand;
  logic              found;

`ifndef PARITY_FIXED_PRIO_EN
  logic [IDW-1:0]    last_grant;
`endif

  // Split the flat data bus into one word per requester.
  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign words[g] = data[g*WIDTH +: WIDTH];
  end

  assign any_req    = |req;
  assign last_shift = (count == CW'(WIDTH - 1));

  // Arbiter: scan from the slot after search_base and wrap around. The first
  // requesting slot found wins. Fixed priority is the same scan with the base
  // pinned to the top index, so the scan starts at requester 0.
  // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
`ifdef PARITY_FIXED_PRIO_EN
    search_base = IDW'(NREQ - 1);
`else
    search_base = last_grant;
`endif
    winner = '0;
    found  = 1'b0;
    cand   = search_base;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + IDW'(1);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // State register; reset has priority over every transition.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs. The outputs are decoded from the
  // registered state, so they are glitch-free with respect to req.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    ack       = '0;
    case (state)
      IDLE:    if (any_req) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (done) ack = NREQ'(1) << grant_id;
  end

  // Datapath: capture the word on grant, then fold one bit per clock into acc.
  // On the final shift, the folded value goes straight to the parity output.
  // NOTE: the shift register and accumulator are explicitly reset (not left as don't-care storage) so the block comes up in a fully known state.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id   <= '0;
`ifndef PARITY_FIXED_PRIO_EN
      last_grant <= IDW'(NREQ - 1);
`endif
      shift_reg  <= '0;
      acc        <= 1'b0;
      count      <= '0;
      parity     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id   <= winner;
`ifndef PARITY_FIXED_PRIO_EN
            last_grant <= winner;
`endif
            shift_reg  <= words[winner];
            acc        <= 1'b1;
            count      <= '0;
          end
        end
        SHIFT: begin
          acc       <= acc ^ shift_reg[0];
          shift_reg <= shift_reg >> 1;
          count     <= count + CW'(1);
          if (last_shift) parity <= acc ^ shift_reg[0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_sched.sv
// tb_parity_sched: self-checking bench for parity_sched.
// A transaction-level reference model predicts the outputs every cycle. The
// model tracks who was granted, which word was captured, and how many cycles
// have passed since capture. Directed scenarios add constant expectations for
// grant order, latency and parity. A randomized phase follows the directed
// scenarios.
module tb_parity_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] data = '0;
  logic [NREQ-1:0]       ack;
  logic                  done;
  logic                  parity;
  logic [IDW-1:0]        grant_id;
  logic                  busy;

  parity_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data     (data),
    .ack      (ack),
    .done     (done),
    .parity   (parity),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int              n_checks   = 0;
  int              n_pass     = 0;
  int              cyc        = 0;
  bit              chk_en     = 1'b0;
  logic [NREQ-1:0] rearm      = '0;
  bit              raise_next = 1'b0;

  // Reference model state.
  bit               m_busy = 1'b0;
  int               m_t    = 0;
  int               m_gid  = 0;
  int               m_last = NREQ - 1;
  logic [WIDTH-1:0] m_word = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Winner selection from the arbitration rules.
  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    int i;
`ifdef PARITY_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) if (r[k]) return k;
    i = last;
`else
    for (int k = 1; k <= NREQ; k++) begin
      i = (last + k) % NREQ;
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  // Odd parity: the result bit makes the total count of ones odd.
  function automatic logic odd_par(input logic [WIDTH-1:0] w);
    return (($countones(w) % 2) == 0);
  endfunction

  // Model: a capture in idle, then WIDTH shift cycles, one done cycle, and back to idle.
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_t    = 0;
      m_gid  = 0;
      m_last = NREQ - 1;
    end else if (!m_busy) begin
      if (req != '0) begin
        m_gid  = pick(req, m_last);
        m_last = m_gid;
        m_word = data[m_gid*WIDTH +: WIDTH];
        m_busy = 1'b1;
        m_t    = 0;
      end
    end else begin
      m_t++;
      if (m_t > WIDTH) m_busy = 1'b0;
    end
  end

  // One clock: compare at the falling edge, then act as the requesters.
  // A requester drops req when it sees its ack, and may re-raise it one cycle later.
  task automatic cycle();
    bit exp_done;
    @(negedge clk);
    cyc++;
    if (chk_en) begin
      exp_done = m_busy && (m_t == WIDTH);
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(exp_done));
      check("ack", 32'(ack), exp_done ? (32'd1 << m_gid) : 32'd0);
      check("grant_id", 32'(grant_id), 32'(m_gid));
      if (exp_done) check("parity", 32'(parity), 32'(odd_par(m_word)));
    end
    if (raise_next) begin
      req        = req | rearm;
      raise_next = 1'b0;
    end
    if (done) begin
      req = req & ~ack;
      if (rearm != '0) raise_next = 1'b1;
    end
  endtask

  task automatic wait_done(output int id, output int at);
    id = -1;
    at = -1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (done) begin
        id = int'(grant_id);
        at = cyc;
        return;
      end
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_busy(output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (busy) begin
        at = cyc;
        return;
      end
    end
    check("capture_timeout", 32'd0, 32'd1);
  endtask

  task automatic single(input int idx, input logic [WIDTH-1:0] w, input logic ep);
    int c0, id, at;
    data[idx*WIDTH +: WIDTH] = w;
    req[idx] = 1'b1;
    wait_busy(c0);
    wait_done(id, at);
    check("single_latency", 32'(at - c0), 32'(WIDTH));
    check("single_parity", 32'(parity), 32'(ep));
    check("single_ack", 32'(ack), 32'd1 << idx);
    check("single_gid", 32'(id), 32'(idx));
    repeat (2) cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int id, at, c0, acks;
    int ids [5];
    int ats [5];
    int exp_rr [5] = '{0, 1, 2, 3, 0};

    // Reset held two cycles while every requester is asking.
    for (int i = 0; i < NREQ; i++) data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    req = '1;
    rst = 1'b1;
    cycle();
    chk_en = 1'b1;
    repeat (2) begin
      cycle();
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_gid", 32'(grant_id), 32'd0);
      check("rst_parity", 32'(parity), 32'd0);
    end
    rst = 1'b0;

    // Round-robin fairness: all four requesters are pending, and requester 0 re-asks after its ack.
    rearm = 4'b0001;
    for (int n = 0; n < 5; n++) begin
      wait_done(id, at);
      ids[n] = id;
      ats[n] = at;
      check("rr_order", 32'(id), 32'(exp_rr[n]));
      if (n > 0) check("rr_interval", 32'(ats[n] - ats[n-1]), 32'(WIDTH + 2));
    end
    rearm      = '0;
    raise_next = 1'b0;
    req        = '0;
    repeat (3) cycle();

    // Single requests with known parities.
    single(2, 8'hA5, 1'b1);
    single(2, 8'h07, 1'b0);
    single(2, 8'h00, 1'b1);

    // Data change and req drop during SHIFT are ignored.
    data[1*WIDTH +: WIDTH] = 8'h3C;
    req[1] = 1'b1;
    wait_busy(c0);
    repeat (2) cycle();
    data[1*WIDTH +: WIDTH] = 8'h01;
    req[1] = 1'b0;
    wait_done(id, at);
    check("midop_parity", 32'(parity), 32'd1);
    check("midop_ack", 32'(ack), 32'b0010);
    acks = 0;
    repeat (12) begin
      cycle();
      if (ack[1]) acks++;
    end
    check("midop_ack_once", 32'(acks), 32'd0);

    // Reset at count=3 aborts the word; the held request is served afterwards.
    data[2*WIDTH +: WIDTH] = 8'hA5;
    req[2] = 1'b1;
    wait_busy(c0);
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    wait_done(id, at);
    check("abort_latency", 32'(at - cyc + WIDTH), 32'(WIDTH));
    check("abort_gid", 32'(id), 32'd2);
    check("abort_parity", 32'(parity), 32'd1);
    repeat (2) cycle();

    // Requesters 1 and 3 both asking, with requester 1 re-asking after each ack.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req   = 4'b1010;
    rearm = 4'b0010;
    for (int n = 0; n < 3; n++) begin
      wait_done(id, at);
`ifdef PARITY_FIXED_PRIO_EN
      check("prio_order", 32'(id), 32'd1);
`else
      check("prio_order", 32'(id), (n % 2 == 0) ? 32'd1 : 32'd3);
`endif
    end
    rearm      = '0;
    raise_next = 1'b0;
`ifdef PARITY_FIXED_PRIO_EN
    wait_done(id, at);
    check("prio_last", 32'(id), 32'd3);
`endif
    repeat (12) cycle();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NREQ; i++) data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) req = req | NREQ'($urandom_range(0, (1 << NREQ) - 1));
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    req = '0;
    repeat (WIDTH + 4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parity_sched.md
# parity_sched

Shared-engine scheduler for bit-serial odd-parity generation. Up to NREQ requesters each present a WIDTH-bit word. The block grants one requester at a time, round-robin by default, and runs one serial parity engine over the granted word at one bit per clock. It returns the parity bit with a one-cycle ack to the owner. It sits between multiple client datapaths and a single, time-multiplexed parity resource.

## Interface
- NREQ, 4: number of requesters, 2..8
- WIDTH, 8: data word width, 1..32
- IDW, $clog2(NREQ): width of grant_id
- clk  in  1  sole clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level, held until that requester's ack
- data  in  NREQ*WIDTH  word of requester i at bits [i*WIDTH +: WIDTH]
- ack  out  NREQ  one-cycle pulse to the requester whose result is ready
- done  out  1  result-valid pulse, coincident with ack
- parity  out  1  odd-parity bit of the granted word; valid while done=1
- grant_id  out  IDW  index of the current or last granted requester
- busy  out  1  high from capture until the done cycle, inclusive

## Operation
- FSM states:
  - IDLE: busy=0.
  - SHIFT: count 0..WIDTH-1.
  - DONE: single cycle.
- IDLE → SHIFT when any req bit is 1 at a clock edge. On that same edge:
  - select the winner;
  - set grant_id;
  - load shift_reg from the winner's data slice;
  - set acc=1 and count=0.
- SHIFT: each edge sets acc ^= shift_reg[0], shifts shift_reg right by 1, and increments count.
- After WIDTH shifts, go to DONE. The final acc is registered to parity, with done=1 and ack[grant_id]=1.
- Result: parity = ~^word. Together with the word, the total count of ones is odd.
- DONE → IDLE unconditionally. ack, done and parity-valid last exactly one cycle.
- Arbitration (default): round-robin. Search starts at last_grant+1 and wraps modulo NREQ. last_grant updates on capture.
- data is sampled only at the capture edge. Later changes to data, or a req deassertion during SHIFT/DONE, are ignored. The operation completes and ack is still issued.
- Requester rule: deassert req on the edge where ack=1 is sampled. A req still high in the IDLE cycle after DONE is treated as a new request.
- Reset values:
  - state=IDLE, ack=0, done=0, parity=0, busy=0, grant_id=0;
  - last_grant=NREQ-1, so requester 0 wins first;
  - shift_reg=0, acc=0, count=0.
- rst during SHIFT or DONE aborts the operation. No ack or done is issued for the aborted word. The requester keeps req high and is re-arbitrated after reset.

## Timing
- The capture edge is E0. done/ack are high during the cycle following edge E0+WIDTH, i.e. WIDTH cycles after capture.
- The IDLE state lasts one cycle minimum between operations. Back-to-back throughput is one word per WIDTH+2 cycles.
- WIDTH=1: one SHIFT cycle. done is high in the cycle after E0+1.
- rst has priority over every transition on the same edge.
- Requests arriving during SHIFT/DONE wait. They are considered at the first IDLE edge.

## Configuration
- PARITY_FIXED_PRIO_EN:
  - Defined: fixed priority, lowest index wins. last_grant is not used.
  - Undefined: round-robin as above.
  - All timing, handshakes and parity behaviour are identical in both builds.

## Test plan
- Reset then idle: assert rst 2 cycles with req=4'b1111 → ack=0, done=0, busy=0, grant_id=0 during reset. After release, the first grant goes to 0.
- Single request (NREQ=4, WIDTH=8):
  - req[2]=1 with data slice 8'hA5 → done/ack=4'b0100 exactly 8 cycles after capture, parity=1, grant_id=2.
  - Repeat with 8'h07 → parity=0.
  - Repeat with 8'h00 → parity=1.
- Round-robin fairness: hold req=4'b1111, each requester dropping on its ack → grant order 0,1,2,3,0. Successive done pulses are 10 cycles apart.
- Mid-operation changes: change data and drop req[1] during SHIFT → parity still reflects the captured word, and ack[1] still pulses once.
- Reset mid-SHIFT: assert rst at count=3 → no done/ack. After release with req still high, a full operation completes with correct parity.
- PARITY_FIXED_PRIO_EN build: hold req=4'b1010 continuously, re-raising after ack → requester 1 is granted every time and requester 3 is never granted until req[1]=0.
